// File: rtl/intersectie_if.sv
// Lamp/request bundle between the intersection scheduler and its surroundings.
// The mod_noapte request line exists only when SEMAFOR_NOAPTE_EN is defined.
interface intersectie_if;
    logic       cerere_b;
    logic       buton;
    logic [2:0] lumini_a;
    logic [2:0] lumini_b;
    logic       semafor_pietoni;
`ifdef SEMAFOR_NOAPTE_EN
    logic       mod_noapte;

    modport master (output cerere_b, buton, mod_noapte,
                    input  lumini_a, lumini_b, semafor_pietoni);
    modport slave  (input  cerere_b, buton, mod_noapte,
                    output lumini_a, lumini_b, semafor_pietoni);
`else
    modport master (output cerere_b, buton,
                    input  lumini_a, lumini_b, semafor_pietoni);
    modport slave  (input  cerere_b, buton,
                    output lumini_a, lumini_b, semafor_pietoni);
`endif
endinterface

// File: rtl/intersectie_ctrl.sv
// Phase scheduler for a two-road intersection with a pedestrian crossing.
// Optional night (blinking yellow) mode is enabled by defining SEMAFOR_NOAPTE_EN.
//
// state      | meaning
// A_VERDE    | road A green (default phase)
// A_GALBEN   | road A yellow
// ROSU_TOT   | all-red clearance, then grant to the next requester
// B_VERDE    | road B green
// B_GALBEN   | road B yellow
// PIETONI    | pedestrians walk, both roads red
// NOAPTE     | night mode, both roads blink yellow (SEMAFOR_NOAPTE_EN only)
module intersectie_ctrl #(
    parameter int CNT_W       = 4,
    parameter int T_VERDE_MIN = 3,
    parameter int T_VERDE_MAX = 6,
    parameter int T_GALBEN    = 1,
    parameter int T_ROSU_TOT  = 1,
    parameter int T_PIETONI   = 2
) (
    input logic          clk,
    input logic          rst_n,
    intersectie_if.slave bus
);
    localparam logic [2:0] S_A_VERDE  = 3'd0;
    localparam logic [2:0] S_A_GALBEN = 3'd1;
    localparam logic [2:0] S_ROSU_TOT = 3'd2;
    localparam logic [2:0] S_B_VERDE  = 3'd3;
    localparam logic [2:0] S_B_GALBEN = 3'd4;
    localparam logic [2:0] S_PIETONI  = 3'd5;
`ifdef SEMAFOR_NOAPTE_EN
    localparam logic [2:0] S_NOAPTE   = 3'd6;
`endif

    localparam logic [1:0] P_A    = 2'd0;
    localparam logic [1:0] P_B    = 2'd1;
    localparam logic [1:0] P_PIET = 2'd2;

    localparam logic [CNT_W-1:0] TMR_MAX     = '1;
    localparam logic [CNT_W-1:0] LIM_VMIN    = CNT_W'(T_VERDE_MIN - 1);
    localparam logic [CNT_W-1:0] LIM_VMAX    = CNT_W'(T_VERDE_MAX - 1);
    localparam logic [CNT_W-1:0] LIM_GALBEN  = CNT_W'(T_GALBEN - 1);
    localparam logic [CNT_W-1:0] LIM_ROSU    = CNT_W'(T_ROSU_TOT - 1);
    localparam logic [CNT_W-1:0] LIM_PIETONI = CNT_W'(T_PIETONI - 1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [1:0]       prev, prev_nxt;
    logic             latch, latch_nxt;
    logic             rr, rr_nxt;
    logic             noapte_req;
    logic             blink_nxt;
    logic [2:0]       lum_a_nxt, lum_b_nxt;
    logic             ped_nxt;

`ifdef SEMAFOR_NOAPTE_EN
    logic blink;
    assign noapte_req = bus.mod_noapte;
    assign blink_nxt  = (state == S_NOAPTE) ? ~blink : 1'b1;
`else
    assign noapte_req = 1'b0;
    assign blink_nxt  = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        rr_nxt    = rr;
        case (state)
            S_A_VERDE:
                if (timer >= LIM_VMIN && (bus.cerere_b || latch)) state_nxt = S_A_GALBEN;
            S_A_GALBEN:
                if (timer == LIM_GALBEN) begin
                    state_nxt = S_ROSU_TOT;
                    prev_nxt  = P_A;
                end
            S_ROSU_TOT:
                if (timer == LIM_ROSU) begin
                    if (noapte_req) begin
`ifdef SEMAFOR_NOAPTE_EN
                        state_nxt = S_NOAPTE;
`endif
                    end else if (prev == P_A) begin
                        // Both pending: round-robin bit decides, then flips
                        if (bus.cerere_b && latch) begin
                            state_nxt = rr ? S_B_VERDE : S_PIETONI;
                            rr_nxt    = ~rr;
                        end else if (bus.cerere_b) state_nxt = S_B_VERDE;
                        else if (latch)            state_nxt = S_PIETONI;
                        else                       state_nxt = S_A_VERDE;
                    end else if (prev == P_B) begin
                        state_nxt = latch ? S_PIETONI : S_A_VERDE;
                    end else begin
                        state_nxt = bus.cerere_b ? S_B_VERDE : S_A_VERDE;
                    end
                end
            S_B_VERDE:
                if (timer == LIM_VMAX || (!bus.cerere_b && timer >= LIM_VMIN))
                    state_nxt = S_B_GALBEN;
            S_B_GALBEN:
                if (timer == LIM_GALBEN) begin
                    state_nxt = S_ROSU_TOT;
                    prev_nxt  = P_B;
                end
            S_PIETONI:
                if (timer == LIM_PIETONI) begin
                    state_nxt = S_ROSU_TOT;
                    prev_nxt  = P_PIET;
                end
`ifdef SEMAFOR_NOAPTE_EN
            S_NOAPTE:
                if (!noapte_req) begin
                    state_nxt = S_ROSU_TOT;
                    prev_nxt  = P_B;
                end
`endif
            default: begin
                state_nxt = S_ROSU_TOT;
                prev_nxt  = P_PIET;
            end
        endcase
    end

    always_comb begin
        timer_nxt = (state_nxt != state) ? '0 :
                    (timer == TMR_MAX)   ? timer : timer + 1'b1;
        latch_nxt = latch;
        if (state_nxt == S_PIETONI && state != S_PIETONI) latch_nxt = 1'b0;
`ifdef SEMAFOR_NOAPTE_EN
        else if (state_nxt == S_NOAPTE)                   latch_nxt = 1'b0;
`endif
        else if (bus.buton && state != S_PIETONI)         latch_nxt = 1'b1;
    end

    // Lamps are decoded from the next state so the registers track the state exactly
    always_comb begin
        lum_a_nxt = 3'b100;
        lum_b_nxt = 3'b100;
        ped_nxt   = 1'b0;
        case (state_nxt)
            S_A_VERDE:  lum_a_nxt = 3'b001;
            S_A_GALBEN: lum_a_nxt = 3'b010;
            S_B_VERDE:  lum_b_nxt = 3'b001;
            S_B_GALBEN: lum_b_nxt = 3'b010;
            S_PIETONI:  ped_nxt   = 1'b1;
`ifdef SEMAFOR_NOAPTE_EN
            S_NOAPTE: begin
                lum_a_nxt = {1'b0, blink_nxt, 1'b0};
                lum_b_nxt = {1'b0, blink_nxt, 1'b0};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= S_A_VERDE;
            timer               <= '0;
            prev                <= P_A;
            latch               <= 1'b0;
            rr                  <= 1'b0;
            bus.lumini_a        <= 3'b001;
            bus.lumini_b        <= 3'b100;
            bus.semafor_pietoni <= 1'b0;
`ifdef SEMAFOR_NOAPTE_EN
            blink               <= 1'b0;
`endif
        end else begin
            state               <= state_nxt;
            timer               <= timer_nxt;
            prev                <= prev_nxt;
            latch               <= latch_nxt;
            rr                  <= rr_nxt;
            bus.lumini_a        <= lum_a_nxt;
            bus.lumini_b        <= lum_b_nxt;
            bus.semafor_pietoni <= ped_nxt;
`ifdef SEMAFOR_NOAPTE_EN
            blink               <= blink_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_intersectie_ctrl.sv
// Randomized bench for intersectie_ctrl against a phase-level reference model,
// plus fixed timelines for the held side-road request and mid-phase reset.
module tb_intersectie_ctrl;
    localparam int T_VERDE_MIN = 3;
    localparam int T_VERDE_MAX = 6;
    localparam int T_GALBEN    = 1;
    localparam int T_ROSU_TOT  = 1;
    localparam int T_PIETONI   = 2;

    localparam int PH_AV = 0, PH_AY = 1, PH_RR = 2, PH_BV = 3, PH_BY = 4, PH_PED = 5;
    localparam int FROM_A = 0, FROM_B = 1, FROM_P = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    intersectie_if bus ();
    intersectie_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase, cycles spent in it, where the last phase came from
    int m_ph, m_age, m_from;
    bit m_rr, m_ped_wait;

    function automatic int phase_len(int ph);
        case (ph)
            PH_AY, PH_BY: return T_GALBEN;
            PH_RR:        return T_ROSU_TOT;
            PH_PED:       return T_PIETONI;
            default:      return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = PH_AV; m_age = 0; m_from = FROM_A; m_rr = 0; m_ped_wait = 0;
    endtask

    task automatic model_step(input bit cb, input bit bt);
        int nxt;
        bit done;
        nxt  = m_ph;
        done = (phase_len(m_ph) != 0) && (m_age + 1 >= phase_len(m_ph));
        if (m_ph == PH_AV) begin
            if (m_age + 1 >= T_VERDE_MIN && (cb || m_ped_wait)) nxt = PH_AY;
        end else if (m_ph == PH_BV) begin
            if (m_age + 1 == T_VERDE_MAX || (!cb && m_age + 1 >= T_VERDE_MIN)) nxt = PH_BY;
        end else if (done) begin
            if (m_ph == PH_AY) begin nxt = PH_RR; m_from = FROM_A; end
            else if (m_ph == PH_BY) begin nxt = PH_RR; m_from = FROM_B; end
            else if (m_ph == PH_PED) begin nxt = PH_RR; m_from = FROM_P; end
            else if (m_from == FROM_A) begin
                if (cb && m_ped_wait) begin
                    nxt  = m_rr ? PH_BV : PH_PED;
                    m_rr = !m_rr;
                end else nxt = cb ? PH_BV : (m_ped_wait ? PH_PED : PH_AV);
            end else if (m_from == FROM_B) nxt = m_ped_wait ? PH_PED : PH_AV;
            else nxt = cb ? PH_BV : PH_AV;
        end
        if (nxt == PH_PED && m_ph != PH_PED) m_ped_wait = 0;
        else if (bt && m_ph != PH_PED) m_ped_wait = 1;
        m_age = (nxt == m_ph) ? m_age + 1 : 0;
        m_ph  = nxt;
    endtask

    function automatic logic [2:0] exp_a(int ph);
        return (ph == PH_AV) ? 3'b001 : (ph == PH_AY) ? 3'b010 : 3'b100;
    endfunction
    function automatic logic [2:0] exp_b(int ph);
        return (ph == PH_BV) ? 3'b001 : (ph == PH_BY) ? 3'b010 : 3'b100;
    endfunction

    task automatic tick(input bit cb, input bit bt, input bit rs);
        @(negedge clk);
        bus.cerere_b = cb;
        bus.buton    = bt;
        rst_n        = rs;
        @(posedge clk);
        if (!rs) model_reset();
        else model_step(cb, bt);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_a"},   {5'd0, bus.lumini_a}, {5'd0, exp_a(m_ph)});
        check({tag, "_b"},   {5'd0, bus.lumini_b}, {5'd0, exp_b(m_ph)});
        check({tag, "_ped"}, {7'd0, bus.semafor_pietoni}, {7'd0, (m_ph == PH_PED)});
    endtask

    logic [2:0] t2_a [14] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100,
                              3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    logic [2:0] t2_b [14] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001,
                              3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100};

`ifdef SEMAFOR_NOAPTE_EN
    initial bus.mod_noapte = 1'b0;
`endif

    initial begin
        bit cb;
        bit bt;
        bit rs;
        bus.cerere_b = 1'b0;
        bus.buton    = 1'b0;
        model_reset();

        tick(0, 0, 0);
        tick(0, 0, 0);
        check_model("reset");

        // Idle road A stays green
        for (int i = 0; i < 50; i++) begin
            tick(0, 0, 1);
            check_model("idle");
        end

        // Held side-road request: fixed timeline from reset release
        tick(1, 0, 0);
        check("t2_a", {5'd0, bus.lumini_a}, {5'd0, t2_a[0]});
        check("t2_b", {5'd0, bus.lumini_b}, {5'd0, t2_b[0]});
        for (int k = 1; k < 14; k++) begin
            tick(1, 0, 1);
            check("t2_a", {5'd0, bus.lumini_a}, {5'd0, t2_a[k]});
            check("t2_b", {5'd0, bus.lumini_b}, {5'd0, t2_b[k]});
            check_model("t2");
        end

        // Reset during B green with a latched press: straight back to A green, latch gone
        tick(1, 0, 0);
        for (int k = 1; k <= 6; k++) tick(1, (k == 6), 1);
        check("t5_bgreen", {5'd0, bus.lumini_b}, 8'h01);
        tick(1, 0, 0);
        check("t5_a", {5'd0, bus.lumini_a}, 8'h01);
        check("t5_b", {5'd0, bus.lumini_b}, 8'h04);
        check("t5_ped", {7'd0, bus.semafor_pietoni}, 8'h00);
        for (int k = 0; k < 20; k++) begin
            tick(0, 0, 1);
            check_model("t5");
        end

        // Randomized traffic against the model
        cb = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) cb = !cb;
            bt = ($urandom_range(0, 11) == 0);
            rs = ($urandom_range(0, 199) != 0);
            tick(cb, bt, rs);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
